// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants.
package vga_timing_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FCNT_W  = 8;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows: 656..751 and 490..491.
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/pix_tick_div.sv
// System-clock to pixel-clock divider; pix_tick marks the last clk of each pixel.
module pix_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Free-running modulo-CLK_DIV counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign pix_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/visible decode, frame tick and scroll strobe.
// Timing parameters default to 640x480@60; smaller rasters are allowed for bring-up.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SCROLL_FRAMES = 1,
    parameter int unsigned H_ACTIVE      = H_VISIBLE,
    parameter int unsigned H_FRONT       = H_FP,
    parameter int unsigned H_PULSE       = H_SYNC,
    parameter int unsigned H_BACK        = H_BP,
    parameter int unsigned V_ACTIVE      = V_VISIBLE,
    parameter int unsigned V_FRONT       = V_FP,
    parameter int unsigned V_PULSE       = V_SYNC,
    parameter int unsigned V_BACK        = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scroll_run,
    output logic             pix_tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_tick,
    output logic             scroll_en
);

    localparam int unsigned H_LAST   = H_ACTIVE + H_FRONT + H_PULSE + H_BACK - 1;
    localparam int unsigned V_LAST   = V_ACTIVE + V_FRONT + V_PULSE + V_BACK - 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_PULSE - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_PULSE - 1;

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(SCROLL_FRAMES - 1);

    logic              h_last;
    logic              v_last;
    logic              line_wrap;
    logic              frame_wrap;
    logic [FCNT_W-1:0] fcnt;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    assign h_last     = (h_cnt == CNT_W'(H_LAST));
    assign v_last     = (v_cnt == CNT_W'(V_LAST));
    assign line_wrap  = pix_tick && h_last;
    assign frame_wrap = line_wrap && v_last;

    // Horizontal counter advances once per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
        end else if (pix_tick) begin
            h_cnt <= h_last ? '0 : h_cnt + CNT_W'(1);
        end
    end

    // Vertical counter advances on each horizontal wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_cnt <= '0;
        end else if (line_wrap) begin
            v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        end
    end

    // Frame tick and scroll strobe land in the first clk at (0,0); scroll_run is sampled on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
            scroll_en  <= 1'b0;
            fcnt       <= '0;
        end else begin
            frame_tick <= frame_wrap;
            scroll_en  <= frame_wrap && scroll_run && (fcnt == FCNT_LAST);
            if (frame_wrap && scroll_run) begin
                fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + FCNT_W'(1);
            end
        end
    end

    assign valid = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hsync = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END)));
    assign vsync = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END)));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size raster instance and a shrunken raster instance
// are compared each clk against an arithmetic model of the raster.
module tb_vga_timing_gen;

    typedef struct packed {
        int unsigned div;
        int unsigned sf;
        int unsigned ha, hf, hp, hb;
        int unsigned va, vf, vp, vb;
    } cfg_t;

    typedef struct packed {
        logic       pix_tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       frame_tick;
        logic       scroll_en;
    } obs_t;

    typedef struct {
        obs_t   o;
        longint c;
    } entry_t;

    localparam cfg_t CFG_A = '{div: 4, sf: 1, ha: 640, hf: 16, hp: 96, hb: 48,
                               va: 480, vf: 10, vp: 2, vb: 33};
    localparam cfg_t CFG_B = '{div: 3, sf: 3, ha: 12, hf: 2, hp: 3, hb: 3,
                               va: 6, vf: 1, vp: 2, vb: 1};
    localparam longint FRAME_B = 3 * 20 * 10;

    localparam obs_t RESET_OBS = '{pix_tick: 1'b0, h: 10'd0, v: 10'd0, valid: 1'b1,
                                   hsync: 1'b1, vsync: 1'b1, frame_tick: 1'b0, scroll_en: 1'b0};

    logic clk;
    logic rst_n;
    logic scroll_run;

    logic       pt_a, val_a, hs_a, vs_a, ft_a, se_a;
    logic [9:0] h_a, v_a;
    logic       pt_b, val_b, hs_b, vs_b, ft_b, se_b;
    logic [9:0] h_b, v_b;
    obs_t       obs_a, obs_b;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    entry_t q_a[$];
    entry_t q_b[$];

    longint      c;
    bit          run_prev;
    int unsigned fcnt_a, fcnt_b;

    vga_timing_gen #(
        .CLK_DIV       (4),
        .SCROLL_FRAMES (1)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .scroll_run (scroll_run),
        .pix_tick   (pt_a),
        .h_cnt      (h_a),
        .v_cnt      (v_a),
        .valid      (val_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .frame_tick (ft_a),
        .scroll_en  (se_a)
    );

    vga_timing_gen #(
        .CLK_DIV       (3),
        .SCROLL_FRAMES (3),
        .H_ACTIVE (12), .H_FRONT (2), .H_PULSE (3), .H_BACK (3),
        .V_ACTIVE (6),  .V_FRONT (1), .V_PULSE (2), .V_BACK (1)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .scroll_run (scroll_run),
        .pix_tick   (pt_b),
        .h_cnt      (h_b),
        .v_cnt      (v_b),
        .valid      (val_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .frame_tick (ft_b),
        .scroll_en  (se_b)
    );

    assign obs_a = {pt_a, h_a, v_a, val_a, hs_a, vs_a, ft_a, se_a};
    assign obs_b = {pt_b, h_b, v_b, val_b, hs_b, vs_b, ft_b, se_b};

    always #5 clk = ~clk;

    // Expected outputs for clk c after reset release, derived from elapsed time alone.
    function automatic obs_t model(input cfg_t k, input longint cc, input bit run_last,
                                   inout int unsigned fcnt);
        obs_t   o;
        longint dv    = longint'(k.div);
        longint ht    = longint'(k.ha + k.hf + k.hp + k.hb);
        longint vt    = longint'(k.va + k.vf + k.vp + k.vb);
        longint frame = dv * ht * vt;
        longint pixel = cc / dv;
        longint h     = pixel % ht;
        longint v     = (pixel / ht) % vt;
        longint hs0   = longint'(k.ha + k.hf);
        longint vs0   = longint'(k.va + k.vf);
        o.pix_tick   = (cc % dv) == dv - 1;
        o.h          = 10'(h);
        o.v          = 10'(v);
        o.valid      = (h < longint'(k.ha)) && (v < longint'(k.va));
        o.hsync      = !((h >= hs0) && (h < hs0 + longint'(k.hp)));
        o.vsync      = !((v >= vs0) && (v < vs0 + longint'(k.vp)));
        o.frame_tick = (cc > 0) && (cc % frame == 0);
        o.scroll_en  = 1'b0;
        if (o.frame_tick && run_last) begin
            if (fcnt + 1 == k.sf) begin
                fcnt        = 0;
                o.scroll_en = 1'b1;
            end else begin
                fcnt = fcnt + 1;
            end
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pt=%b h=%0d v=%0d valid=%b hs=%b vs=%b ft=%b se=%b",
                         o.pix_tick, o.h, o.v, o.valid, o.hsync, o.vsync,
                         o.frame_tick, o.scroll_en);
    endfunction

    task automatic check(input string name, input longint cc, input obs_t got, input obs_t exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s clk %0d: got {%s} required {%s}", name, cc, fmt(got), fmt(exp));
        end
    endtask

    // Issue one clk of stimulus per call and queue the model's expectation.
    task automatic run(input int n);
        entry_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e.c = c;
            e.o = model(CFG_A, c, run_prev, fcnt_a);
            q_a.push_back(e);
            e.o = model(CFG_B, c, run_prev, fcnt_b);
            q_b.push_back(e);
            if ((c % FRAME_B) == FRAME_B - 1) begin
                scroll_run = ($urandom_range(0, 2) != 0);
            end else if ($urandom_range(0, 299) == 0) begin
                scroll_run = !scroll_run;
            end
            run_prev = scroll_run;
            c++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        c        = 0;
        fcnt_a   = 0;
        fcnt_b   = 0;
        run_prev = 1'b0;
    endtask

    // Monitor: pops one expectation per clk per instance and compares.
    always begin
        entry_t e;
        @(negedge clk);
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("dut_a", e.c, obs_a, e.o);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("dut_b", e.c, obs_b, e.o);
        end
    end

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        scroll_run = 1'b1;
        pass_cnt   = 0;
        total_cnt  = 0;
        c          = 0;
        fcnt_a     = 0;
        fcnt_b     = 0;
        run_prev   = 1'b0;

        repeat (5) @(negedge clk);
        #1;
        check("reset_a", -1, obs_a, RESET_OBS);
        check("reset_b", -1, obs_b, RESET_OBS);

        release_reset();
        run(7000);

        // Asynchronous reset in mid-line (dut_a) and mid-frame (dut_b).
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", c, obs_a, RESET_OBS);
        check("async_reset_b", c, obs_b, RESET_OBS);
        repeat (3) @(negedge clk);

        release_reset();
        run(2600);

        @(negedge clk);
        #3;
        total_cnt++;
        if (q_a.size() == 0 && q_b.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: got %0d/%0d pending entries, required 0/0", q_a.size(), q_b.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
